// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, static predecode-based next-PC prediction,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [12:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_instr,
    output logic        o_if_id_pred_taken,
    output logic [31:0] o_if_id_pred_target
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    logic [31:0] pc_r;
    logic [31:0] imm_s;
    logic        pred_taken_s;
    logic [31:0] pred_target_s;
    logic [31:0] redirect_aligned_s;
    logic [31:0] next_pc_s;

    logic        valid_r;
    logic [31:0] if_pc_r;
    logic [31:0] instr_r;
    logic        pred_taken_r;
    logic [31:0] pred_target_r;

    assign o_imem_addr = pc_r[12:0];

    // Predecode: every branch and JAL is predicted taken; JALR has no static target.
    always_comb begin
        pred_taken_s = 1'b0;
        imm_s        = 32'h0000_0000;
        case (i_imem_rdata[6:0])
            OP_BRANCH: begin
                pred_taken_s = 1'b1;
                imm_s        = b_imm(i_imem_rdata);
            end
            OP_JAL: begin
                pred_taken_s = 1'b1;
                imm_s        = j_imm(i_imem_rdata);
            end
            default: begin
                pred_taken_s = 1'b0;
                imm_s        = 32'h0000_0000;
            end
        endcase
        if (pred_taken_s) begin
            pred_target_s = pc_r + imm_s;
        end else begin
            pred_target_s = pc_r + 32'h0000_0004;
        end
    end

    // Next-PC select: a redirect overrides a stall, which overrides the prediction.
    always_comb begin
        redirect_aligned_s = i_redirect_pc & 32'hFFFF_FFFC;
        if (i_redirect_valid) begin
            next_pc_s = redirect_aligned_s;
        end else if (i_stall) begin
            next_pc_s = pc_r;
        end else begin
            next_pc_s = pred_target_s;
        end
    end

    // PC register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // IF/ID register: squashed to a NOP bubble on redirect, frozen on stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r       <= 1'b0;
            if_pc_r       <= 32'h0000_0000;
            instr_r       <= NOP_INSTR;
            pred_taken_r  <= 1'b0;
            pred_target_r <= 32'h0000_0000;
        end else if (i_redirect_valid) begin
            valid_r       <= 1'b0;
            if_pc_r       <= 32'h0000_0000;
            instr_r       <= NOP_INSTR;
            pred_taken_r  <= 1'b0;
            pred_target_r <= 32'h0000_0000;
        end else if (i_stall) begin
            valid_r       <= valid_r;
            if_pc_r       <= if_pc_r;
            instr_r       <= instr_r;
            pred_taken_r  <= pred_taken_r;
            pred_target_r <= pred_target_r;
        end else begin
            valid_r       <= 1'b1;
            if_pc_r       <= pc_r;
            instr_r       <= i_imem_rdata;
            pred_taken_r  <= pred_taken_s;
            pred_target_r <= pred_target_s;
        end
    end

    assign o_if_id_valid       = valid_r;
    assign o_if_id_pc          = if_pc_r;
    assign o_if_id_instr       = instr_r;
    assign o_if_id_pred_taken  = pred_taken_r;
    assign o_if_id_pred_target = pred_target_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural instruction memory, a queue of
// expected IF/ID slots, a table of predecode vectors and hand-written corner sequences.
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI     = 32'h0010_8093;
    localparam logic [31:0] BEQ_M8   = 32'hFE00_0CE3;
    localparam logic [31:0] JAL_P100 = 32'h1000_006F;
    localparam logic [31:0] JALR     = 32'h0000_8067;
    localparam logic [31:0] BNE_MAX  = 32'h7E00_1FE3;
    localparam logic [31:0] JAL_M8   = 32'hFF9F_F06F;
    localparam logic [31:0] LUI      = 32'h0000_12B7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_pred_taken;
    logic [31:0] if_id_pred_target;

    logic [31:0] mem [0:2047];

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } slot_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } vec_t;

    slot_t sb_q[$];
    vec_t  vecs[7];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[12:2]];

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .o_imem_addr        (imem_addr),
        .i_imem_rdata       (imem_rdata),
        .i_stall            (stall),
        .i_redirect_valid   (redirect_valid),
        .i_redirect_pc      (redirect_pc),
        .o_if_id_valid      (if_id_valid),
        .o_if_id_pc         (if_id_pc),
        .o_if_id_instr      (if_id_instr),
        .o_if_id_pred_taken (if_id_pred_taken),
        .o_if_id_pred_target(if_id_pred_target)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_if_id(input string tag, input slot_t e);
        chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, e.valid});
        chk({tag, " pc"}, if_id_pc, e.pc);
        chk({tag, " instr"}, if_id_instr, e.instr);
        chk({tag, " pred_taken"}, {31'd0, if_id_pred_taken}, {31'd0, e.taken});
        chk({tag, " pred_target"}, if_id_pred_target, e.target);
    endtask

    task automatic push(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic tk, input logic [31:0] tgt);
        slot_t s;
        s.valid  = v;
        s.pc     = pc;
        s.instr  = instr;
        s.taken  = tk;
        s.target = tgt;
        sb_q.push_back(s);
    endtask

    task automatic pop_check(input string tag, output slot_t got);
        got = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0};
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            got = sb_q.pop_front();
            chk_if_id(tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        slot_t last;
        logic [31:0] vpc;

        for (int i = 0; i < 2048; i++) mem[i] = ADDI;
        mem[32'h10 >> 2] = BEQ_M8;

        vecs[0] = '{32'h0000_0020, JAL_P100, 1'b1, 32'h0000_0120};
        vecs[1] = '{32'h0000_0040, JALR,     1'b0, 32'h0000_0044};
        vecs[2] = '{32'h0000_0010, BEQ_M8,   1'b1, 32'h0000_0008};
        vecs[3] = '{32'h0000_0100, BNE_MAX,  1'b1, 32'h0000_10FE};
        vecs[4] = '{32'h0000_0004, JAL_M8,   1'b1, 32'hFFFF_FFFC};
        vecs[5] = '{32'h0000_0060, LUI,      1'b0, 32'h0000_0064};
        vecs[6] = '{32'h0000_7FFC, ADDI,     1'b0, 32'h0000_8000};

        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        // Reset values, then release between edges.
        #12;
        chk("reset imem_addr", {19'd0, imem_addr}, 32'd0);
        chk_if_id("reset", '{1'b0, 32'd0, NOP, 1'b0, 32'd0});
        rst_n = 1'b1;

        // Straight-line ADDI run.
        push(1'b1, 32'h0, ADDI, 1'b0, 32'h4);
        tick();
        chk("seq addr 4", {19'd0, imem_addr}, 32'h4);
        pop_check("seq pc0", last);
        push(1'b1, 32'h4, ADDI, 1'b0, 32'h8);
        tick();
        chk("seq addr 8", {19'd0, imem_addr}, 32'h8);
        pop_check("seq pc4", last);
        push(1'b1, 32'h8, ADDI, 1'b0, 32'hC);
        tick();
        chk("seq addr C", {19'd0, imem_addr}, 32'hC);
        pop_check("seq pc8", last);

        // Three-cycle stall at 0x0C holds PC and IF/ID.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall addr", {19'd0, imem_addr}, 32'hC);
            chk_if_id("stall hold", last);
        end
        stall = 1'b0;
        push(1'b1, 32'hC, ADDI, 1'b0, 32'h10);
        tick();
        chk("resume addr 10", {19'd0, imem_addr}, 32'h10);
        pop_check("resume pcC", last);

        // BEQ -8 at 0x10 redirects fetch to 0x08 with no bubble.
        push(1'b1, 32'h10, BEQ_M8, 1'b1, 32'h8);
        tick();
        chk("beq next addr", {19'd0, imem_addr}, 32'h8);
        pop_check("beq slot", last);
        push(1'b1, 32'h8, ADDI, 1'b0, 32'hC);
        tick();
        chk("after beq addr", {19'd0, imem_addr}, 32'hC);
        pop_check("after beq slot", last);

        // Redirect wins over stall, low bits cleared, slot squashed.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        push(1'b0, 32'h0, NOP, 1'b0, 32'h0);
        tick();
        chk("redirect addr", {19'd0, imem_addr}, 32'h200);
        pop_check("redirect squash", last);
        stall          = 1'b0;
        redirect_valid = 1'b0;

        // Predecode table: redirect to each vector's PC, then fetch it.
        for (int i = 0; i < 7; i++) begin
            vpc = vecs[i].pc;
            mem[vpc[12:2]] = vecs[i].instr;
            redirect_valid = 1'b1;
            redirect_pc    = vpc;
            push(1'b0, 32'h0, NOP, 1'b0, 32'h0);
            tick();
            chk($sformatf("vec%0d addr", i), {19'd0, imem_addr}, {19'd0, vpc[12:0]});
            pop_check($sformatf("vec%0d bubble", i), last);
            redirect_valid = 1'b0;
            push(1'b1, vpc, vecs[i].instr, vecs[i].taken, vecs[i].target);
            tick();
            vpc = vecs[i].target;
            chk($sformatf("vec%0d next addr", i), {19'd0, imem_addr}, {19'd0, vpc[12:0]});
            pop_check($sformatf("vec%0d slot", i), last);
        end

        // Asynchronous reset mid-cycle at pc 0x80, with stall+redirect discarded.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        push(1'b0, 32'h0, NOP, 1'b0, 32'h0);
        tick();
        redirect_valid = 1'b0;
        pop_check("pre-reset bubble", last);
        push(1'b1, 32'h80, ADDI, 1'b0, 32'h84);
        tick();
        pop_check("pc80 slot", last);
        chk("pre-reset addr", {19'd0, imem_addr}, 32'h84);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset addr", {19'd0, imem_addr}, 32'h0);
        chk_if_id("async reset", '{1'b0, 32'd0, NOP, 1'b0, 32'd0});
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        chk("held reset addr", {19'd0, imem_addr}, 32'h0);
        chk_if_id("held reset", '{1'b0, 32'd0, NOP, 1'b0, 32'd0});
        stall          = 1'b0;
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        push(1'b1, 32'h0, ADDI, 1'b0, 32'h4);
        tick();
        chk("post-reset addr", {19'd0, imem_addr}, 32'h4);
        pop_check("post-reset slot", last);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d leftover expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
